alu_pipe: RTL and testbench

Parametrised, elastic-pipelined ALU that replaces the fixed single-register ALU plus flag register file. It accepts one operation per cycle over a valid/ready handshake and carries result and flags through STAGES register stages. Downstream back-pressure stalls the pipeline without loss or duplication. It sits between operand fetch and register write-back in the datapath.

---
 rtl/alu_pipe_pkg.sv | 22 ++
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encodings and the flag bundle shared by the ALU
// datapath (alu_core) and the elastic pipeline wrapper (alu_pipe).
package alu_pipe_pkg;

    // 3-bit opcode encoding
    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // Flags travelling alongside each result through the pipe
    typedef struct packed {
        logic overflow;
        logic zero;
        logic carry;
    } alu_flags_t;

endpackage : alu_pipe_pkg

// File: rtl/alu_core.sv
// alu_core: purely combinational WIDTH-bit ALU producing a result and the
// {overflow, zero, carry} flags. SUB and SLT share one adder fed with ~b and
// a carry-in of 1, so SUB's carry-out reads 1 when no borrow occurs.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int MSB = WIDTH - 1;

    logic             sub_s;
    logic [WIDTH-1:0] b_op_s;
    logic [WIDTH:0]   sum_s;
    logic             add_ovf_s;
    logic             lt_s;

    // Shared adder: a + b for ADD, a + ~b + 1 for SUB/SLT
    always_comb begin
        sub_s = (op == OP_SUB) || (op == OP_SLT);
        if (sub_s) begin
            b_op_s = ~b;
        end else begin
            b_op_s = b;
        end
        sum_s = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};
        // Same-sign addends whose sum changes sign overflowed; with ~b this
        // reduces to the usual subtraction rule (signs differ, sign flips).
        add_ovf_s = (a[MSB] == b_op_s[MSB]) && (sum_s[MSB] != a[MSB]);
        // True signed order: differing signs decide directly, otherwise the
        // difference cannot overflow and its sign is the answer.
        if (a[MSB] != b[MSB]) begin
            lt_s = a[MSB];
        end else begin
            lt_s = sum_s[MSB];
        end
    end

    // Opcode decode into result and flags
    always_comb begin
        result         = a;
        flags.overflow = 1'b0;
        flags.carry    = 1'b0;
        case (op)
            OP_MOV:  result = a;
            OP_NOT:  result = ~a;
            OP_ADD: begin
                result         = sum_s[MSB:0];
                flags.carry    = sum_s[WIDTH];
                flags.overflow = add_ovf_s;
            end
            OP_NOR:  result = ~(a | b);
            OP_SUB: begin
                result         = sum_s[MSB:0];
                flags.carry    = sum_s[WIDTH];
                flags.overflow = add_ovf_s;
            end
            OP_NAND: result = ~(a & b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            OP_AND:  result = a & b;
            default: result = a;
        endcase
        flags.zero = (result == {WIDTH{1'b0}});
    end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// alu_pipe: elastic STAGES-deep pipeline around alu_core with a valid/ready
// handshake on both sides. Each stage holds valid, result and flags; a stage
// loads whenever it is empty or its contents move on, so back-pressure fills
// bubbles first and in_ready only drops with every stage full and stalled.
// Optional feature: define ALU_PIPE_STICKY_EN to add sticky_ovf/sticky_clr.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_PIPE_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_ovf,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             carry
);

    localparam int LAST = STAGES - 1;

    logic [WIDTH-1:0] core_res_s;
    alu_flags_t       core_flg_s;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    alu_flags_t        flg_q [STAGES];
    alu_flags_t        flg_d [STAGES];

    logic [STAGES-1:0] stage_rdy_s;
    logic              rdy_chain_s;
    logic              out_fire_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (core_res_s),
        .flags  (core_flg_s)
    );

    // Ready chain from the output backwards: a stage can load when it is
    // empty or everything downstream of it is able to move.
    always_comb begin
        rdy_chain_s = out_ready;
        for (int i = LAST; i >= 0; i--) begin
            stage_rdy_s[i] = !vld_q[i] || rdy_chain_s;
            rdy_chain_s    = stage_rdy_s[i];
        end
    end

    // Next-state for every stage: load from upstream when ready, else hold
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < STAGES; i++) begin
            res_d[i] = res_q[i];
            flg_d[i] = flg_q[i];
        end
        // stage 1 loads straight from the ALU
        if (stage_rdy_s[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                res_d[0] = core_res_s;
                flg_d[0] = core_flg_s;
            end else begin
                res_d[0] = res_q[0];
                flg_d[0] = flg_q[0];
            end
        end else begin
            vld_d[0] = vld_q[0];
        end
        // later stages load from their predecessor; data only changes when
        // a valid item arrives so outputs hold while out_valid is low
        for (int i = 1; i < STAGES; i++) begin
            if (stage_rdy_s[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    res_d[i] = res_q[i-1];
                    flg_d[i] = flg_q[i-1];
                end else begin
                    res_d[i] = res_q[i];
                    flg_d[i] = flg_q[i];
                end
            end else begin
                vld_d[i] = vld_q[i];
            end
        end
    end

    // Stage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= {WIDTH{1'b0}};
                flg_q[i] <= 3'b000;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= res_d[i];
                flg_q[i] <= flg_d[i];
            end
        end
    end

    assign in_ready   = stage_rdy_s[0];
    assign out_valid  = vld_q[LAST];
    assign result     = res_q[LAST];
    assign overflow   = flg_q[LAST].overflow;
    assign zero       = flg_q[LAST].zero;
    assign carry      = flg_q[LAST].carry;
    assign out_fire_s = vld_q[LAST] && out_ready;

`ifdef ALU_PIPE_STICKY_EN
    logic sticky_q;
    logic sticky_d;

    // Sticky overflow: an overflowing output transfer wins over a clear
    always_comb begin
        sticky_d = sticky_q;
        if (out_fire_s && flg_q[LAST].overflow) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`else
    logic unused_fire_s;
    assign unused_fire_s = out_fire_s;
`endif

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=32, STAGES=3).
// A queue-based scoreboard holds expected {result, overflow, zero, carry}
// computed from plain signed/unsigned arithmetic for every accepted op.
// Sticky checks are compiled when ALU_PIPE_STICKY_EN is defined.
module tb_alu_pipe;

    localparam int W = 32;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;
    logic         carry;
    logic         clr_drv;
`ifdef ALU_PIPE_STICKY_EN
    logic         sticky_clr;
    logic         sticky_ovf;
    assign sticky_clr = clr_drv;
`endif

    int checks = 0;
    int errors = 0;

    // scoreboard / model state
    logic [W+2:0] exp_q[$];
    logic         sticky_m;
    // per-tick observations
    logic [W+2:0] obs_v;
    logic [W+2:0] exp_v;
    logic         obs_valid;
    logic         obs_in_ready;
    logic         out_seen;
    int           occ_v;

    alu_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ALU_PIPE_STICKY_EN
        .sticky_clr(sticky_clr),
        .sticky_ovf(sticky_ovf),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {result, overflow, zero, carry}
    function automatic logic [W+2:0] ref_alu(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
        logic [W:0]   u;
        logic [W-1:0] r;
        logic         v;
        logic         c;
        longint       sx;
        longint       sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v  = 1'b0;
        c  = 1'b0;
        case (o)
            3'd0: r = x;
            3'd1: r = ~x;
            3'd2: begin
                u = {1'b0, x} + {1'b0, y};
                r = u[W-1:0];
                c = u[W];
                v = (sx + sy) != longint'($signed(r));
            end
            3'd3: r = ~(x | y);
            3'd4: begin
                r = x - y;
                c = (x >= y);
                v = (sx - sy) != longint'($signed(r));
            end
            3'd5: r = ~(x & y);
            3'd6: r = (sx < sy) ? 32'd1 : 32'd0;
            default: r = x & y;
        endcase
        return {r, v, (r == 32'd0), c};
    endfunction

    // Advance one clock: sample before the edge, update the model at the edge
    task automatic tick();
        logic fire_in;
        logic fire_out;
        #1;
        fire_in      = in_valid && in_ready;
        fire_out     = out_valid && out_ready;
        obs_v        = {result, overflow, zero, carry};
        obs_valid    = out_valid;
        obs_in_ready = in_ready;
        occ_v        = exp_q.size();
        out_seen     = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            sticky_m = 1'b0;
        end else begin
            if (fire_out) begin
                out_seen = 1'b1;
                if (exp_q.size() > 0) exp_v = exp_q.pop_front();
                else                  exp_v = 'x;
                if (exp_v[2] === 1'b1) sticky_m = 1'b1;
                else if (clr_drv)      sticky_m = 1'b0;
            end else if (clr_drv) begin
                sticky_m = 1'b0;
            end
            if (fire_in) exp_q.push_back(ref_alu(op, a, b));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if ({result, overflow, zero, carry} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {result, overflow, zero, carry});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef ALU_PIPE_STICKY_EN
        checks++;
        if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", sticky_ovf); end
`endif
    endtask

    task automatic test_directed();
        // op, a, b, {result, ovf, zero, carry}
        logic [2:0]   t_op [13];
        logic [W-1:0] t_a  [13];
        logic [W-1:0] t_b  [13];
        logic [W+2:0] t_e  [13];
        logic         got;
        t_op[0]  = 3'd2; t_a[0]  = 32'hFFFFFFFF; t_b[0]  = 32'hFFFFFFFF; t_e[0]  = {32'hFFFFFFFE, 3'b001};
        t_op[1]  = 3'd2; t_a[1]  = 32'h7FFFFFFF; t_b[1]  = 32'h00000001; t_e[1]  = {32'h80000000, 3'b100};
        t_op[2]  = 3'd4; t_a[2]  = 32'hFFFFFFFF; t_b[2]  = 32'hFFFFFFFF; t_e[2]  = {32'h00000000, 3'b011};
        t_op[3]  = 3'd4; t_a[3]  = 32'd5;        t_b[3]  = 32'd12;       t_e[3]  = {32'hFFFFFFF9, 3'b000};
        t_op[4]  = 3'd6; t_a[4]  = 32'h7FFFFFFF; t_b[4]  = 32'h80000001; t_e[4]  = {32'h00000000, 3'b010};
        t_op[5]  = 3'd6; t_a[5]  = 32'hFFFFFFFF; t_b[5]  = 32'd5;        t_e[5]  = {32'h00000001, 3'b000};
        t_op[6]  = 3'd6; t_a[6]  = 32'd25;       t_b[6]  = 32'd25;       t_e[6]  = {32'h00000000, 3'b010};
        t_op[7]  = 3'd3; t_a[7]  = 32'hAAAAAAAA; t_b[7]  = 32'h55555555; t_e[7]  = {32'h00000000, 3'b010};
        t_op[8]  = 3'd4; t_a[8]  = 32'h80000000; t_b[8]  = 32'd1;        t_e[8]  = {32'h7FFFFFFF, 3'b101};
        t_op[9]  = 3'd1; t_a[9]  = 32'd0;        t_b[9]  = 32'd7;        t_e[9]  = {32'hFFFFFFFF, 3'b000};
        t_op[10] = 3'd5; t_a[10] = 32'hFFFFFFFF; t_b[10] = 32'hFFFFFFFF; t_e[10] = {32'h00000000, 3'b010};
        t_op[11] = 3'd7; t_a[11] = 32'hF0F0F0F0; t_b[11] = 32'h3C3C3C3C; t_e[11] = {32'h30303030, 3'b000};
        t_op[12] = 3'd0; t_a[12] = 32'd0;        t_b[12] = 32'hFFFFFFFF; t_e[12] = {32'h00000000, 3'b010};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; op = t_op[i]; a = t_a[i]; b = t_b[i];
            tick();
            in_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                tick();
                if (out_seen) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL directed_timeout[%0d]: no output within 8 cycles", i);
            end else begin
                if (obs_v !== t_e[i]) begin
                    errors++; $display("FAIL directed[%0d]: got %h want %h", i, obs_v, t_e[i]);
                end
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL directed_model[%0d]: got %h want %h", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic exp_ov;
        out_ready = 1'b1; op = 3'd0; b = 32'd0;
        for (int t = 0; t < 15; t++) begin
            in_valid = (t < 10);
            a = 32'(t + 1);
            tick();
            exp_ov = (t >= 3) && (t <= 12);
            checks++;
            if (obs_valid !== exp_ov) begin
                errors++; $display("FAIL stream_valid[t=%0d]: got %b want %b", t, obs_valid, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (obs_v[W+2:3] !== 32'(t - 2)) begin
                    errors++; $display("FAIL stream_data[t=%0d]: got %0d want %0d", t, obs_v[W+2:3], t - 2);
                end
            end
            if (t < 10) begin
                checks++;
                if (obs_in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_in_ready[t=%0d]: got %b want 1", t, obs_in_ready);
                end
            end
        end
    endtask

    // Drive ticks checking in_ready, stall stability and scoreboard order
    task automatic run_traffic(int n, int mode, output logic saw_drop);
        logic         prev_stall;
        logic [W+2:0] prev_obs;
        logic         exp_rdy;
        prev_stall = 1'b0;
        prev_obs   = '0;
        saw_drop   = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (mode == 0) begin
                in_valid  = 1'b1; op = 3'd0; a = 32'(100 + t); b = $urandom;
                out_ready = !(t >= 4 && t < 10);
            end else if (mode == 1) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                op        = 3'($urandom_range(0, 7));
                a         = ($urandom_range(0, 2) == 0) ? 32'h7FFFFFFF << $urandom_range(0, 1) : $urandom;
                b         = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF >> $urandom_range(0, 31) : $urandom;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            tick();
            exp_rdy = (occ_v < S) || out_ready;
            checks++;
            if (obs_in_ready !== exp_rdy) begin
                errors++; $display("FAIL in_ready[m%0d t=%0d]: got %b want %b", mode, t, obs_in_ready, exp_rdy);
            end
            if (!obs_in_ready) saw_drop = 1'b1;
            if (prev_stall) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_v !== prev_obs) begin
                    errors++; $display("FAIL stall_hold[m%0d t=%0d]: got %b/%h want 1/%h", mode, t, obs_valid, obs_v, prev_obs);
                end
            end
            if (out_seen) begin
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL scoreboard[m%0d t=%0d]: got %h want %h", mode, t, obs_v, exp_v);
                end
            end
            prev_stall = obs_valid && !out_ready;
            prev_obs   = obs_v;
        end
    endtask

    task automatic test_backpressure();
        logic drop;
        logic dummy;
        run_traffic(20, 0, drop);
        run_traffic(8, 2, dummy);
        checks++;
        if (drop !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop: got %b want 1", drop); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic dummy;
        run_traffic(400, 1, dummy);
        run_traffic(8, 2, dummy);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 32'h7FFFFFFF; b = 32'd1;
        tick();
        a = 32'h12345678; b = 32'h11111111;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({out_valid, result, overflow, zero, carry} !== 36'd0) begin
            errors++; $display("FAIL midrst_outputs: got %h want 0", {out_valid, result, overflow, zero, carry});
        end
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++;
            if (obs_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost[t=%0d]: got %b want 0", t, obs_valid); end
        end
    endtask

`ifdef ALU_PIPE_STICKY_EN
    task automatic test_sticky();
        // overflowing ADD sets sticky, MOVs leave it
        out_ready = 1'b1; clr_drv = 1'b0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 4); op = (t == 0) ? 3'd2 : 3'd0; a = 32'h7FFFFFFF; b = 32'd1;
            tick();
            checks++;
            if (sticky_ovf !== sticky_m) begin errors++; $display("FAIL sticky_set[t=%0d]: got %b want %b", t, sticky_ovf, sticky_m); end
        end
        checks++;
        if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_persist: got %b want 1", sticky_ovf); end
        clr_drv = 1'b1; tick(); clr_drv = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b want 0", sticky_ovf); end
        // park an overflowing result at the output, then transfer it and clear together
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd4; a = 32'h80000000; b = 32'd1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 6 && !out_valid; t++) tick();
        out_ready = 1'b1; clr_drv = 1'b1;
        tick();
        clr_drv = 1'b0;
        checks++;
        if (sticky_ovf !== 1'b1 || sticky_m !== 1'b1) begin
            errors++; $display("FAIL sticky_set_clear: got %b want 1", sticky_ovf);
        end
        clr_drv = 1'b1; tick(); clr_drv = 1'b0;
        checks++;
        if (sticky_ovf !== sticky_m) begin errors++; $display("FAIL sticky_clear2: got %b want %b", sticky_ovf, sticky_m); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_drv = 1'b0;
        a = 32'd0; b = 32'd0; op = 3'd0; sticky_m = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef ALU_PIPE_STICKY_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_pipe
